// File: rtl/mem_stage.sv
// MEM-stage data-memory access unit and MEM/WB pipeline register.
// Drives a ready-handshaked word bus, stalls upstream while an access is pending, flags misalignment and timeout.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WBin,
    input  logic [2:0]  Min,
    input  logic [31:0] ALUin,
    input  logic [31:0] WDin,
    input  logic [4:0]  Rdin,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [1:0]  WBout,
    output logic [31:0] RDout,
    output logic [31:0] ALUout,
    output logic [4:0]  Rdout,
    output logic        misalign,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       access, aligned, go, complete, rd_done, bad;

    assign access    = Min[1] | Min[0];
    assign aligned   = (ALUin[1:0] == 2'b00);
    assign go        = access & aligned;
    assign mem_addr  = ALUin;
    assign mem_wdata = WDin;
    // A read+write combination is issued as a plain write.
    assign mem_we    = Min[0];
    assign timeout   = (state == ERR);
    assign complete  = mem_req & mem_ready;
    assign rd_done   = complete & ~Min[0];
    assign bad       = access & ~aligned & (state == IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_req      = 1'b0;
        stall        = 1'b0;
        case (state)
            IDLE: begin
                mem_req = go;
                stall   = go & ~mem_ready;
                if (go && !mem_ready) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                stall   = ~mem_ready;
                if (mem_ready) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == 8'(MAX_WAIT)) begin
                    state_nxt = ERR;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                stall = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            WBout    <= 2'b00;
            RDout    <= 32'd0;
            ALUout   <= 32'd0;
            Rdout    <= 5'd0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (bad)
                misalign <= 1'b1;
            if (stall) begin
                WBout  <= 2'b00;
                RDout  <= 32'd0;
                ALUout <= 32'd0;
                Rdout  <= 5'd0;
            end else begin
                // A misaligned access is squashed by dropping RegWrite.
                WBout  <= {WBin[1] & ~bad, WBin[0]};
                RDout  <= rd_done ? mem_rdata : 32'd0;
                ALUout <= ALUin;
                Rdout  <= Rdin;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: single-cycle vector table plus multi-cycle wait, timeout and reset sequences.
module tb_mem_stage;

    logic        clk, rst;
    logic [1:0]  WBin;
    logic [2:0]  Min;
    logic [31:0] ALUin, WDin;
    logic [4:0]  Rdin;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready, stall;
    logic [1:0]  WBout;
    logic [31:0] RDout, ALUout;
    logic [4:0]  Rdout;
    logic        misalign, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .WBin(WBin), .Min(Min), .ALUin(ALUin), .WDin(WDin),
        .Rdin(Rdin), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
        .WBout(WBout), .RDout(RDout), .ALUout(ALUout), .Rdout(Rdout),
        .misalign(misalign), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic        e_stall;
        logic [1:0]  e_wb;
        logic [31:0] e_rdo;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
        logic        e_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic ready);
        Min = m; WBin = wb; ALUin = alu; WDin = wd; Rdin = rd;
        mem_rdata = rdata; mem_ready = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic [1:0] wb, input logic [31:0] rdo,
                            input logic [31:0] alu, input logic [4:0] rd);
        check({tag, " WBout"}, 32'(WBout), 32'(wb));
        check({tag, " RDout"}, RDout, rdo);
        check({tag, " ALUout"}, ALUout, alu);
        check({tag, " Rdout"}, 32'(Rdout), 32'(rd));
    endtask

    int stall_cnt;

    initial begin
        rst = 1'b1;
        drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);

        //            m       wb     alu         wd            rd     rdata         rdy   req   stl   e_wb   e_rdo         e_alu       e_rd  mis
        vecs[0] = '{3'b000, 2'b10, 32'h1234, 32'h0,        5'd3, 32'h0,        1'b0, 1'b0, 1'b0, 2'b10, 32'h0,        32'h1234, 5'd3, 1'b0};
        vecs[1] = '{3'b010, 2'b11, 32'h100,  32'h0,        5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 2'b11, 32'hDEADBEEF, 32'h100,  5'd5, 1'b0};
        vecs[2] = '{3'b001, 2'b00, 32'h200,  32'h12345678, 5'd0, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0,        32'h200,  5'd0, 1'b0};
        vecs[3] = '{3'b011, 2'b10, 32'h204,  32'h87654321, 5'd7, 32'h11112222, 1'b1, 1'b1, 1'b0, 2'b10, 32'h0,        32'h204,  5'd7, 1'b0};
        vecs[4] = '{3'b100, 2'b11, 32'h3,    32'h0,        5'd2, 32'h33334444, 1'b1, 1'b0, 1'b0, 2'b11, 32'h0,        32'h3,    5'd2, 1'b0};
        vecs[5] = '{3'b010, 2'b11, 32'h102,  32'h0,        5'd9, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0,        32'h102,  5'd9, 1'b1};
        vecs[6] = '{3'b010, 2'b11, 32'h108,  32'h0,        5'd4, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 2'b11, 32'h0BADF00D, 32'h108,  5'd4, 1'b1};
        vecs[7] = '{3'b000, 2'b10, 32'h55,   32'h0,        5'd1, 32'h0,        1'b0, 1'b0, 1'b0, 2'b10, 32'h0,        32'h55,   5'd1, 1'b1};

        tick();
        rst = 1'b0;
        check_wb("reset", 2'b00, 32'h0, 32'h0, 5'd0);
        check("reset misalign", 32'(misalign), 32'h0);
        check("reset timeout", 32'(timeout), 32'h0);

        // Single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].m, vecs[i].wb, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].rdata, vecs[i].ready);
            check($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            check($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].m[0]));
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].alu);
            check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wd);
            tick();
            check_wb($sformatf("vec%0d", i), vecs[i].e_wb, vecs[i].e_rdo, vecs[i].e_alu, vecs[i].e_rd);
            check($sformatf("vec%0d misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
        end

        // Store with 3 wait states
        do_reset();
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            drive(3'b001, 2'b00, 32'h40, 32'h12345678, 5'd0, 32'h0, 1'b0);
            check($sformatf("st3 c%0d mem_req", c), 32'(mem_req), 32'h1);
            check($sformatf("st3 c%0d mem_we", c), 32'(mem_we), 32'h1);
            check($sformatf("st3 c%0d mem_wdata", c), mem_wdata, 32'h12345678);
            if (stall) stall_cnt++;
            tick();
            check_wb($sformatf("st3 bubble%0d", c), 2'b00, 32'h0, 32'h0, 5'd0);
        end
        drive(3'b001, 2'b00, 32'h40, 32'h12345678, 5'd0, 32'h0, 1'b1);
        check("st3 c3 mem_req", 32'(mem_req), 32'h1);
        check("st3 c3 mem_we", 32'(mem_we), 32'h1);
        if (stall) stall_cnt++;
        check("st3 stall count", 32'(stall_cnt), 32'd3);
        tick();
        check_wb("st3 done", 2'b00, 32'h0, 32'h40, 5'd0);

        // Mixed stream: ALU op, zero-wait load, 2-wait store, ALU op
        do_reset();
        drive(3'b000, 2'b10, 32'h11, 32'h0, 5'd1, 32'h0, 1'b0);
        tick();
        check_wb("mix alu1", 2'b10, 32'h0, 32'h11, 5'd1);
        drive(3'b010, 2'b11, 32'h20, 32'h0, 5'd2, 32'h55AA55AA, 1'b1);
        check("mix ld stall", 32'(stall), 32'h0);
        tick();
        check_wb("mix ld", 2'b11, 32'h55AA55AA, 32'h20, 5'd2);
        for (int c = 0; c < 2; c++) begin
            drive(3'b001, 2'b00, 32'h30, 32'hFEEDFACE, 5'd0, 32'h99999999, 1'b0);
            check($sformatf("mix st c%0d stall", c), 32'(stall), 32'h1);
            tick();
            check_wb($sformatf("mix bubble%0d", c), 2'b00, 32'h0, 32'h0, 5'd0);
        end
        drive(3'b001, 2'b00, 32'h30, 32'hFEEDFACE, 5'd0, 32'h99999999, 1'b1);
        check("mix st done stall", 32'(stall), 32'h0);
        tick();
        check_wb("mix st", 2'b00, 32'h0, 32'h30, 5'd0);
        drive(3'b000, 2'b10, 32'h44, 32'h0, 5'd6, 32'h0, 1'b0);
        check("mix alu2 mem_req", 32'(mem_req), 32'h0);
        tick();
        check_wb("mix alu2", 2'b10, 32'h0, 32'h44, 5'd6);

        // Load completing on the last allowed wait cycle (15 waits)
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(3'b010, 2'b11, 32'h90, 32'h0, 5'd8, 32'h0, 1'b0);
            check($sformatf("w15 c%0d stall", c), 32'(stall), 32'h1);
            tick();
        end
        drive(3'b010, 2'b11, 32'h90, 32'h0, 5'd8, 32'h600DCAFE, 1'b1);
        check("w15 last mem_req", 32'(mem_req), 32'h1);
        check("w15 last stall", 32'(stall), 32'h0);
        tick();
        check("w15 timeout", 32'(timeout), 32'h0);
        check_wb("w15 done", 2'b11, 32'h600DCAFE, 32'h90, 5'd8);

        // Timeout: ready never arrives
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(3'b010, 2'b11, 32'h80, 32'h0, 5'd3, 32'h0, 1'b0);
            check($sformatf("to c%0d mem_req", c), 32'(mem_req), 32'h1);
            check($sformatf("to c%0d stall", c), 32'(stall), 32'h1);
            check($sformatf("to c%0d timeout", c), 32'(timeout), 32'h0);
            tick();
        end
        check("to err timeout", 32'(timeout), 32'h1);
        check("to err mem_req", 32'(mem_req), 32'h0);
        check("to err stall", 32'(stall), 32'h1);
        drive(3'b010, 2'b11, 32'h80, 32'h0, 5'd3, 32'h77777777, 1'b1);
        tick();
        check("to err hold timeout", 32'(timeout), 32'h1);
        check("to err hold mem_req", 32'(mem_req), 32'h0);
        check_wb("to err bubble", 2'b00, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_wb("to rst", 2'b00, 32'h0, 32'h0, 5'd0);
        check("to rst timeout", 32'(timeout), 32'h0);
        check("to rst misalign", 32'(misalign), 32'h0);
        drive(3'b000, 2'b10, 32'h70, 32'h0, 5'd2, 32'h0, 1'b0);
        check("to idle mem_req", 32'(mem_req), 32'h0);
        check("to idle stall", 32'(stall), 32'h0);
        tick();
        check_wb("to idle pass", 2'b10, 32'h0, 32'h70, 5'd2);

        // Reset in the 2nd wait cycle
        do_reset();
        drive(3'b010, 2'b11, 32'h60, 32'h0, 5'd3, 32'h0, 1'b0);
        tick();
        check("rw wait stall", 32'(stall), 32'h1);
        rst = 1'b1;
        tick();
        check_wb("rw rst", 2'b00, 32'h0, 32'h0, 5'd0);
        check("rw rst timeout", 32'(timeout), 32'h0);
        check("rw req follows inputs", 32'(mem_req), 32'h1);
        rst = 1'b0;
        drive(3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        check("rw idle mem_req", 32'(mem_req), 32'h0);
        check("rw idle stall", 32'(stall), 32'h0);
        tick();
        drive(3'b010, 2'b11, 32'h64, 32'h0, 5'd7, 32'h13572468, 1'b1);
        check("rw ld stall", 32'(stall), 32'h0);
        tick();
        check_wb("rw ld", 2'b11, 32'h13572468, 32'h64, 5'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM-stage access unit plus MEM/WB pipeline register for the pipelined MIPS core. It consumes the EX/MEM register outputs (WB/M control, ALU result, store data, destination register) and drives a ready-handshaked data-memory bus. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB fields for write-back. Word accesses only; misalignment and bus timeout are flagged.

## Interface
Parameters:
- MAX_WAIT, 15: maximum stall cycles per access before timeout (1..255).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- WBin  input  2  {RegWrite, MemtoReg} from EX/MEM.
- Min  input  3  {Branch, MemRead, MemWrite} from EX/MEM; Branch is ignored here.
- ALUin  input  32  ALU result, which is the memory byte address for loads and stores.
- WDin  input  32  store data.
- Rdin  input  5  destination register.
- mem_addr  output  32  bus address, always equal to ALUin.
- mem_wdata  output  32  bus write data, always equal to WDin.
- mem_req  output  1  bus request (combinational).
- mem_we  output  1  1 = write, 0 = read.
- mem_rdata  input  32  read data; sampled only when mem_ready = 1.
- mem_ready  input  1  access completes in any cycle where mem_req & mem_ready.
- stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational).
- WBout  output  2  registered {RegWrite, MemtoReg}.
- RDout  output  32  registered load data.
- ALUout  output  32  registered ALU result.
- Rdout  output  5  registered destination register.
- misalign  output  1  sticky: access attempted with ALUin[1:0] != 0.
- timeout  output  1  asserted in state ERR.

## Operation
- Definitions:
  - access = Min[1] | Min[0]
  - aligned = (ALUin[1:0] == 2'b00)
  - go = access & aligned
- Both MemRead and MemWrite set: the access is treated as a write only.
- FSM has three states: IDLE, WAIT, ERR.
- IDLE:
  - mem_req = go; mem_we = Min[0].
  - go & mem_ready: complete; stay in IDLE.
  - go & ~mem_ready: go to WAIT, wait_cnt <= 1.
- WAIT:
  - mem_req = 1; stall = ~mem_ready.
  - mem_ready: complete, go to IDLE.
  - Otherwise, if wait_cnt == MAX_WAIT, go to ERR; else wait_cnt <= wait_cnt + 1.
  - wait_cnt is 8-bit and saturates; no wrap.
- ERR:
  - mem_req = 0, stall = 1, timeout = 1.
  - Exits only on rst.
- stall = go & ~mem_ready in IDLE/WAIT, and 1 in ERR.
- MEM/WB register update, each clock:
  - stall = 1: load a bubble (WBout = 0, Rdout = 0, RDout = 0, ALUout = 0).
  - Otherwise: WBout <= WBin, ALUout <= ALUin, Rdout <= Rdin.
  - RDout <= mem_rdata on a completing read; else 0.
- Misaligned access (access & ~aligned):
  - No bus request, no stall.
  - misalign <= 1 (sticky until rst).
  - The instruction passes with WBout[1] forced to 0, so it is squashed.
- Non-memory instruction (access = 0): passes with no request, no stall, RDout = 0.
- The data bus must hold mem_rdata valid only in the mem_ready cycle.

## Timing
- Reset (rst high at posedge):
  - state = IDLE, wait_cnt = 0.
  - WBout, RDout, ALUout, Rdout = 0; misalign = 0; timeout = 0.
  - During the reset cycle, mem_req is combinational from the inputs; the core is held in reset.
- Zero-wait access (ready in the request cycle): no stall; MEM/WB outputs valid 1 cycle after EX/MEM presents the instruction.
- N wait cycles (ready in the (N+1)th request cycle, N <= MAX_WAIT):
  - stall high for N cycles, and N bubbles are emitted.
  - The instruction appears at the MEM/WB outputs the cycle after ready.
- Timeout: ready still low after MAX_WAIT + 1 request cycles leads to ERR on the next edge.
- Back-to-back accesses: a new access may be requested in the cycle after completion; there are no dead cycles.
- rst mid-WAIT: the FSM returns to IDLE and the outstanding request is dropped (mem_req follows the inputs after reset).
- mem_ready while mem_req = 0: ignored.

## Test plan
- Zero-wait load: Min=010, WBin=11, ALUin=0x100, Rdin=5, mem_ready=1, mem_rdata=0xDEADBEEF.
  - Required: stall=0 throughout.
  - Next cycle: WBout=11, RDout=0xDEADBEEF, ALUout=0x100, Rdout=5.
- Store with 3 wait states: Min=001, WDin=0x12345678, ALUin=0x40, ready asserted in the 4th cycle.
  - Required: mem_we=1 and mem_req=1 for 4 cycles; stall=1 for 3 cycles.
  - Required: 3 bubbles (WBout=0), then ALUout=0x40.
- Misaligned load: ALUin=0x102, Min=010, WBin=11.
  - Required: mem_req=0, stall=0.
  - Next cycle: misalign=1, WBout=01, RDout=0. misalign stays set for later instructions.
- Timeout: MAX_WAIT=15, load with mem_ready held 0.
  - Required: stall high; ERR entered after 16 request cycles; timeout=1, mem_req=0.
  - Then rst: all outputs return to 0 and state returns to IDLE.
- Mixed stream: ALU op (Min=000) → zero-wait load → 2-wait store → ALU op.
  - Required: correct MEM/WB sequence with exactly 2 bubbles; RDout=0 for non-loads.
- Reset mid-WAIT: rst asserted in the 2nd wait cycle.
  - Required: outputs all 0 next cycle; mem_req and stall clear once the inputs are idle.
